// File: rtl/fpnew_pkg.sv
// rtl/fpnew_pkg.sv - shared floating-point unit types used by the result buffer
package fpnew_pkg;

   // IEEE exception flags, MSB first: invalid, div-by-zero, overflow, underflow, inexact
   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } status_t;

   localparam logic DONT_CARE = 1'b1;

endpackage

// File: rtl/fpnew_result_fifo.sv
// rtl/fpnew_result_fifo.sv - in-order result buffer between an opgroup block and writeback
// Keeps sticky exception flags of delivered results; in_ready_o derives from state only.
module fpnew_result_fifo #(
   parameter int unsigned  Width    = 32,
   parameter int unsigned  Depth    = 4,
   parameter type          TagType  = logic,
   localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [Width-1:0]    result_i,
   input  fpnew_pkg::status_t  status_i,
   input  logic                extension_bit_i,
   input  TagType              tag_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic                flush_i,
   output logic [Width-1:0]    result_o,
   output fpnew_pkg::status_t  status_o,
   output logic                extension_bit_o,
   output TagType              tag_o,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output fpnew_pkg::status_t  fflags_o,
   input  logic                fflags_clr_i,
   output logic [CntWidth-1:0] usage_o,
   output logic                busy_o
);

   localparam int unsigned         PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
   localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(Depth - 1);
   localparam logic [CntWidth-1:0] FullCnt  = CntWidth'(Depth);

   logic [Width-1:0]    result_q [Depth];
   fpnew_pkg::status_t  status_q [Depth];
   logic                ext_q    [Depth];
   TagType              tag_q    [Depth];

   logic [PtrWidth-1:0] rd_ptr_q;
   logic [PtrWidth-1:0] wr_ptr_q;
   logic [CntWidth-1:0] count_q;
   fpnew_pkg::status_t  fflags_q;
   logic                push;
   logic                pop;

   // Pointers wrap explicitly so Depth need not be a power of two
   function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
      return (p == LastPtr) ? '0 : p + PtrWidth'(1);
   endfunction

   assign in_ready_o  = (count_q != FullCnt);
   assign out_valid_o = (count_q != '0);
   assign push        = in_valid_i & in_ready_o & ~flush_i;
   assign pop         = out_valid_o & out_ready_i & ~flush_i;

   always_ff @(posedge clk_i) begin
      if (push) begin
         result_q[wr_ptr_q] <= result_i;
         status_q[wr_ptr_q] <= status_i;
         ext_q[wr_ptr_q]    <= extension_bit_i;
         tag_q[wr_ptr_q]    <= tag_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         if (push && !pop) begin
            count_q <= count_q + CntWidth'(1);
         end else if (pop && !push) begin
            count_q <= count_q - CntWidth'(1);
         end
      end
   end

   // Clear wipes the accumulated history but keeps the flags of a same-cycle pop
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fflags_q <= '0;
      end else if (fflags_clr_i) begin
         fflags_q <= pop ? status_o : '0;
      end else if (pop) begin
         fflags_q <= fflags_q | status_o;
      end
   end

   assign result_o        = out_valid_o ? result_q[rd_ptr_q]
                                        : {Width{fpnew_pkg::DONT_CARE}};
   assign status_o        = out_valid_o ? status_q[rd_ptr_q]
                                        : fpnew_pkg::status_t'({$bits(fpnew_pkg::status_t){fpnew_pkg::DONT_CARE}});
   assign extension_bit_o = out_valid_o ? ext_q[rd_ptr_q] : fpnew_pkg::DONT_CARE;
   assign tag_o           = out_valid_o ? tag_q[rd_ptr_q]
                                        : TagType'({$bits(TagType){fpnew_pkg::DONT_CARE}});

   assign fflags_o = fflags_q;
   assign usage_o  = count_q;
   assign busy_o   = out_valid_o;

endmodule

// File: tb/tb_fpnew_result_fifo.sv
// tb/tb_fpnew_result_fifo.sv - checks buffers of depth 4, 3 and 1 against a list-based model
module tb_fpnew_result_fifo;

   localparam int NI = 3;
   typedef logic [7:0] tag_t;
   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  st;
      logic        ext;
      tag_t        tag;
   } entry_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] result;
   logic [4:0]  status;
   logic        ext;
   tag_t        tag;
   logic        in_valid, out_ready, flush, fflags_clr;

   logic        in_ready  [NI];
   logic [31:0] res_o     [NI];
   logic [4:0]  st_o      [NI];
   logic        ext_o     [NI];
   tag_t        tag_o     [NI];
   logic        out_valid [NI];
   logic [4:0]  ff_o      [NI];
   logic [3:0]  usage     [NI];
   logic        busy      [NI];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int D = (g == 0) ? 4 : ((g == 1) ? 3 : 1);
      logic [$clog2(D+1)-1:0] use_l;
      fpnew_result_fifo #(.Width(32), .Depth(D), .TagType(tag_t)) u_dut (
         .clk_i(clk), .rst_ni(rst_n),
         .result_i(result), .status_i(status), .extension_bit_i(ext), .tag_i(tag),
         .in_valid_i(in_valid), .in_ready_o(in_ready[g]), .flush_i(flush),
         .result_o(res_o[g]), .status_o(st_o[g]), .extension_bit_o(ext_o[g]), .tag_o(tag_o[g]),
         .out_valid_o(out_valid[g]), .out_ready_i(out_ready),
         .fflags_o(ff_o[g]), .fflags_clr_i(fflags_clr),
         .usage_o(use_l), .busy_o(busy[g])
      );
      assign usage[g] = 4'(use_l);
   end

   function automatic int dep(input int k);
      return (k == 0) ? 4 : ((k == 1) ? 3 : 1);
   endfunction

   // Model: ordered list per instance, element 0 is the head
   entry_t     mq   [NI][8];
   int         mcnt [NI];
   logic [4:0] mff  [NI];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NI; k++) begin
            mcnt[k] = 0;
            mff[k]  = '0;
         end
      end else begin
         for (int k = 0; k < NI; k++) begin
            bit do_pop;
            bit do_push;
            do_pop  = (mcnt[k] != 0) && out_ready && !flush;
            do_push = in_valid && (mcnt[k] != dep(k)) && !flush;
            if (fflags_clr) mff[k] = do_pop ? mq[k][0].st : 5'h00;
            else if (do_pop) mff[k] = mff[k] | mq[k][0].st;
            if (flush) begin
               mcnt[k] = 0;
            end else begin
               if (do_pop) begin
                  for (int i = 0; i < 7; i++) mq[k][i] = mq[k][i+1];
                  mcnt[k] = mcnt[k] - 1;
               end
               if (do_push) begin
                  mq[k][mcnt[k]] = '{res: result, st: status, ext: ext, tag: tag};
                  mcnt[k] = mcnt[k] + 1;
               end
            end
         end
      end
   end

   int total = 0;
   int bad   = 0;

   logic       pe_ff, pe_tag, pe_use, pe_rdy;
   logic [4:0] pv_ff;
   tag_t       pv_tag;
   logic [3:0] pv_use;
   logic       pv_rdy;

   task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d] got=%0h want=%0h at %0t", nm, k, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < NI; k++) begin
         chk("in_ready",  k, 64'(in_ready[k]),  64'(mcnt[k] != dep(k)));
         chk("out_valid", k, 64'(out_valid[k]), 64'(mcnt[k] != 0));
         chk("busy",      k, 64'(busy[k]),      64'(mcnt[k] != 0));
         chk("usage",     k, 64'(usage[k]),     64'(mcnt[k]));
         chk("fflags",    k, 64'(ff_o[k]),      64'(mff[k]));
         if (mcnt[k] != 0) begin
            chk("result", k, 64'(res_o[k]), 64'(mq[k][0].res));
            chk("status", k, 64'(st_o[k]),  64'(mq[k][0].st));
            chk("ext",    k, 64'(ext_o[k]), 64'(mq[k][0].ext));
            chk("tag",    k, 64'(tag_o[k]), 64'(mq[k][0].tag));
         end
      end
      if (pe_ff) begin
         chk("pin_fflags",       0, 64'(ff_o[0]), 64'(pv_ff));
         chk("pin_model_fflags", 0, 64'(mff[0]),  64'(pv_ff));
      end
      if (pe_tag) begin
         chk("pin_head_valid", 0, 64'(out_valid[0]), 64'(1));
         chk("pin_tag",        0, 64'(tag_o[0]),     64'(pv_tag));
         chk("pin_model_tag",  0, 64'(mq[0][0].tag), 64'(pv_tag));
      end
      if (pe_use) begin
         chk("pin_usage",       0, 64'(usage[0]), 64'(pv_use));
         chk("pin_model_usage", 0, 64'(mcnt[0]),  64'(pv_use));
      end
      if (pe_rdy) chk("pin_in_ready", 0, 64'(in_ready[0]), 64'(pv_rdy));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
      pe_ff = 0; pe_tag = 0; pe_use = 0; pe_rdy = 0;
   endtask

   task automatic exp_ff(input logic [4:0] v);  pe_ff = 1;  pv_ff = v;  endtask
   task automatic exp_tag(input tag_t v);       pe_tag = 1; pv_tag = v; endtask
   task automatic exp_use(input logic [3:0] v); pe_use = 1; pv_use = v; endtask
   task automatic exp_rdy(input logic v);       pe_rdy = 1; pv_rdy = v; endtask

   task automatic drive(input tag_t t, input logic [4:0] s);
      in_valid = 1'b1;
      tag      = t;
      status   = s;
      result   = $urandom;
      ext      = 1'($urandom);
   endtask

   initial begin
      rst_n = 0; in_valid = 0; result = '0; status = '0; ext = 0; tag = '0;
      out_ready = 0; flush = 0; fflags_clr = 0;
      pe_ff = 0; pe_tag = 0; pe_use = 0; pe_rdy = 0;
      pv_ff = '0; pv_tag = '0; pv_use = '0; pv_rdy = 0;

      repeat (3) step();
      exp_rdy(1); exp_use(0); exp_ff(0); settle();
      rst_n = 1;
      step();
      exp_rdy(1); exp_use(0); exp_ff(0); settle();

      // Fill the depth-4 buffer, then drain in order
      for (int i = 1; i <= 4; i++) begin
         drive(tag_t'(i), 5'h00);
         step();
      end
      in_valid = 0;
      exp_use(4); exp_rdy(0); settle();
      drive(8'd5, 5'h00);
      step();
      in_valid = 0;
      exp_use(4); exp_tag(8'd1); settle();
      out_ready = 1;
      step();
      exp_tag(8'd2); exp_rdy(1); exp_use(3); settle();
      step();
      exp_tag(8'd3); settle();
      step();
      exp_tag(8'd4); settle();
      step();
      out_ready = 0;
      exp_use(0); settle();

      // Sticky flags
      fflags_clr = 1;
      step();
      fflags_clr = 0;
      exp_ff(5'h00); settle();
      drive(8'h21, 5'h01);
      step();
      drive(8'h22, 5'h05);
      step();
      in_valid = 0;
      out_ready = 1;
      step();
      step();
      out_ready = 0;
      exp_ff(5'h05); settle();
      drive(8'h23, 5'h08);
      step();
      in_valid = 0; out_ready = 1; fflags_clr = 1;
      step();
      out_ready = 0; fflags_clr = 0;
      exp_ff(5'h08); settle();
      fflags_clr = 1;
      step();
      fflags_clr = 0;
      exp_ff(5'h00); settle();

      // Flush with a concurrent push and pop request
      drive(8'h30, 5'h10);
      step();
      in_valid = 0; out_ready = 1;
      step();
      out_ready = 0;
      exp_ff(5'h10); settle();
      for (int i = 0; i < 3; i++) begin
         drive(tag_t'(8'h31 + i), 5'h02);
         step();
      end
      in_valid = 0;
      exp_use(3); exp_tag(8'h31); settle();
      drive(8'h40, 5'h04);
      out_ready = 1; flush = 1;
      step();
      in_valid = 0; out_ready = 0; flush = 0;
      exp_use(0); exp_ff(5'h10); settle();

      // Asynchronous reset between edges
      drive(8'h50, 5'h00);
      step();
      drive(8'h51, 5'h00);
      step();
      in_valid = 0;
      exp_use(2); settle();
      step();
      #2;
      rst_n = 0;
      exp_use(0); exp_ff(5'h00); exp_rdy(1); settle();
      rst_n = 1;
      drive(8'h77, 5'h1f);
      step();
      in_valid = 0;
      exp_tag(8'h77); exp_use(1); settle();
      out_ready = 1;
      step();
      out_ready = 0;

      // Back-to-back stream with writeback always ready
      out_ready = 1;
      for (int i = 0; i < 10; i++) begin
         drive(tag_t'(8'h60 + i), 5'($urandom));
         step();
      end
      in_valid = 0;
      repeat (3) step();
      out_ready = 0;
      exp_use(0); settle();

      // Randomized traffic with varying back-pressure
      for (int n = 0; n < 3000; n++) begin
         int p;
         p = ((n / 500) % 3 == 0) ? 2 : (((n / 500) % 3 == 1) ? 5 : 9);
         drive(tag_t'($urandom), 5'($urandom));
         in_valid   = ($urandom_range(0, 9) < 6);
         out_ready  = ($urandom_range(0, 9) < p);
         flush      = ($urandom_range(0, 63) == 0);
         fflags_clr = ($urandom_range(0, 31) == 0);
         step();
      end
      in_valid = 0; flush = 0; fflags_clr = 0; out_ready = 1;
      repeat (8) step();
      out_ready = 0;
      exp_use(0); settle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
